// File: rtl/vai_tx_sched.sv
// vai_tx_sched: round-robin c0 Tx read-request scheduler with
// per-requester credit caps and drain handshake.
module vai_tx_sched #(
  parameter int NUM_REQ = 16,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic                       pClk,
  input  logic                       SoftReset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       up_almfull,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  input  logic                       rsp_valid,
  input  logic [ID_W-1:0]            rsp_id,
  input  logic [NUM_REQ-1:0]         drain_req,
  output logic [NUM_REQ-1:0]         drain_done,
  output logic [NUM_REQ*CNT_W-1:0]   outstanding,
  output logic                       err_underflow
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } drainSt_e;

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);
  localparam logic [ID_W-1:0]  LastId = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rspHit;
  logic [NUM_REQ-1:0] cntZero;
  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    gntIdx;
  logic [ID_W-1:0]    hiIdx;
  logic [ID_W-1:0]    loIdx;
  logic               hiFound;
  logic               found;
  logic               idBad;
  logic               underflow;
  logic [DATA_W-1:0]  gntData;

  if (NUM_REQ < (1 << ID_W)) begin : gIdChk
    assign idBad = rsp_id > LastId;
  end else begin : gIdFull
    assign idBad = 1'b0;
  end

  assign underflow = rsp_valid & (idBad | (|(rspHit & cntZero)));
  assign req_ready = gnt;

  // Lowest eligible index at/above the pointer wins, else lowest overall.
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        loIdx = ID_W'(i);
        if (i >= int'(rrPtr)) begin
          hiFound = 1'b1;
          hiIdx   = ID_W'(i);
        end
      end
    end
    found  = |elig;
    gntIdx = hiFound ? hiIdx : loIdx;
    gnt    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = found && (gntIdx == ID_W'(i));
    end
  end

  always_comb begin
    gntData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gntData = gntData | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= '0;
      rrPtr         <= '0;
      err_underflow <= 1'b0;
    end else begin
      out_valid <= found;
      if (found) begin
        out_data <= gntData;
        out_id   <= gntIdx;
        rrPtr    <= (gntIdx == LastId) ? '0 : gntIdx + ID_W'(1);
      end
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : gReq
    logic [CNT_W-1:0] cntQ;
    logic             inc;
    logic             dec;
    drainSt_e         st;
    drainSt_e         stNext;

    assign rspHit[i]  = rsp_valid && (rsp_id == ID_W'(i));
    assign cntZero[i] = (cntQ == '0);
    assign elig[i]    = SoftReset_n & req_valid[i] & ~drain_req[i]
                      & (cntQ < MaxOut) & ~up_almfull;
    assign inc        = gnt[i];
    assign dec        = rspHit[i] & ~cntZero[i];

    assign outstanding[i*CNT_W +: CNT_W] = cntQ;
    assign drain_done[i] = (st == DONE);

    always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
        cntQ <= '0;
        st   <= RUN;
      end else begin
        st <= stNext;
        if (inc && !dec) begin
          cntQ <= cntQ + CNT_W'(1);
        end else if (dec && !inc) begin
          cntQ <= cntQ - CNT_W'(1);
        end
      end
    end

    // An idle requester skips DRAIN and completes one cycle after the request.
    always_comb begin
      stNext = st;
      unique case (st)
        RUN: begin
          if (drain_req[i]) begin
            stNext = cntZero[i] ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (!drain_req[i]) begin
            stNext = RUN;
          end else if (cntZero[i]) begin
            stNext = DONE;
          end
        end
        DONE: begin
          if (!drain_req[i]) begin
            stNext = RUN;
          end
        end
        default: stNext = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_vai_tx_sched.sv
// tb_vai_tx_sched: directed stimulus with a reference model and an
// output scoreboard for vai_tx_sched.
module tb_vai_tx_sched;

  localparam int NR = 16;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int MO = 4;
  localparam int CW = 8;

  logic              pClk = 1'b0;
  logic              SoftReset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              up_almfull = 1'b0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic              rsp_valid = 1'b0;
  logic [IW-1:0]     rsp_id = '0;
  logic [NR-1:0]     drain_req = '0;
  logic [NR-1:0]     drain_done;
  logic [NR*CW-1:0]  outstanding;
  logic              err_underflow;

  always #5 pClk = ~pClk;

  vai_tx_sched #(
    .NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .MAX_OUT(MO), .CNT_W(CW)
  ) dut (
    .pClk(pClk),
    .SoftReset_n(SoftReset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .up_almfull(up_almfull),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .drain_req(drain_req),
    .drain_done(drain_done),
    .outstanding(outstanding),
    .err_underflow(err_underflow)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mPtr = 0;
  int   mCnt[NR];
  logic mErr = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] packCnt();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[i*CW +: CW] = CW'(mCnt[i]);
    return r;
  endfunction

  task automatic setData(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic modelReset();
    mPtr = 0;
    mErr = 1'b0;
    for (int i = 0; i < NR; i++) mCnt[i] = 0;
    sb.delete();
  endtask

  // One clock: predict grant at negedge, check registered outputs after posedge.
  task automatic cycle();
    logic [NR-1:0] expR;
    int   g;
    int   j;
    exp_t e;
    @(negedge pClk);
    g = -1;
    for (int k = 0; k < NR; k++) begin
      j = (mPtr + k) % NR;
      if (g < 0 && req_valid[j] && !drain_req[j] && mCnt[j] < MO && !up_almfull)
        g = j;
    end
    expR = '0;
    for (int i = 0; i < NR; i++) expR[i] = (i == g);
    chk("req_ready", 128'(req_ready), 128'(expR));
    if (rsp_valid) begin
      if (int'(rsp_id) >= NR || mCnt[rsp_id] == 0) mErr = 1'b1;
      else mCnt[rsp_id]--;
    end
    if (g >= 0) begin
      e.id   = IW'(g);
      e.data = req_data[g*DW +: DW];
      sb.push_back(e);
      mCnt[g]++;
      mPtr = (g + 1) % NR;
    end
    @(posedge pClk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", 128'(out_valid), 128'(1));
      chk("out_id", 128'(out_id), 128'(e.id));
      chk("out_data", 128'(out_data), 128'(e.data));
    end else begin
      chk("out_valid_idle", 128'(out_valid), 128'(0));
    end
    chk("outstanding", 128'(outstanding), packCnt());
    chk("err_underflow", 128'(err_underflow), 128'(mErr));
  endtask

  initial begin
    modelReset();
    for (int i = 0; i < NR; i++) setData(i, 64'hC0DE_0000_0000_0000 | 64'(i));

    // Reset state, with a request pending
    req_valid[3] = 1'b1;
    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_id", 128'(out_id), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_drain_done", 128'(drain_done), 128'(0));
    chk("rst_err", 128'(err_underflow), 128'(0));
    req_valid = '0;
    @(posedge pClk);
    #1;
    SoftReset_n = 1'b1;

    // Single requester, new payload after each grant
    req_valid[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      setData(3, 64'hA300 + 64'(n));
      cycle();
    end
    req_valid = '0;
    cycle();
    chk("single_cnt3", 128'(outstanding[3*CW +: CW]), 128'(4));

    // Fairness among 0, 5, 9
    req_valid[0] = 1'b1;
    req_valid[5] = 1'b1;
    req_valid[9] = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    req_valid = '0;
    cycle();
    chk("fair_cnt0", 128'(outstanding[0 +: CW]), 128'(2));
    chk("fair_cnt9", 128'(outstanding[9*CW +: CW]), 128'(2));

    // Almost-full gating
    req_valid[0] = 1'b1;
    req_valid[5] = 1'b1;
    up_almfull = 1'b1;
    for (int n = 0; n < 10; n++) cycle();
    up_almfull = 1'b0;
    for (int n = 0; n < 2; n++) cycle();
    req_valid = '0;
    cycle();

    // Credit cap on requester 1
    req_valid[1] = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    chk("cap_cnt1", 128'(outstanding[1*CW +: CW]), 128'(MO));
    rsp_id = 4'd1;
    rsp_valid = 1'b1;
    cycle();
    cycle();
    rsp_valid = 1'b0;
    cycle();
    cycle();
    chk("cap_cnt1_after", 128'(outstanding[1*CW +: CW]), 128'(MO));
    req_valid = '0;
    cycle();

    // Drain requester 7 with three reads in flight
    req_valid[7] = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    drain_req[7] = 1'b1;
    cycle();
    cycle();
    chk("drain7_busy", 128'(drain_done[7]), 128'(0));
    rsp_id = 4'd7;
    rsp_valid = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    rsp_valid = 1'b0;
    cycle();
    chk("drain7_done", 128'(drain_done[7]), 128'(1));
    drain_req[7] = 1'b0;
    cycle();
    chk("drain7_release", 128'(drain_done[7]), 128'(0));
    req_valid = '0;
    cycle();

    // Drain of an idle requester completes in one cycle
    drain_req[2] = 1'b1;
    cycle();
    chk("drain2_done", 128'(drain_done[2]), 128'(1));
    drain_req[2] = 1'b0;
    cycle();
    chk("drain2_release", 128'(drain_done[2]), 128'(0));

    // Underflow is sticky
    rsp_id = 4'd2;
    rsp_valid = 1'b1;
    cycle();
    rsp_valid = 1'b0;
    cycle();
    cycle();
    chk("err_sticky", 128'(err_underflow), 128'(1));

    // Asynchronous reset mid-burst
    req_valid[10] = 1'b1;
    req_valid[11] = 1'b1;
    cycle();
    cycle();
    #2;
    SoftReset_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_outstanding", 128'(outstanding), 128'(0));
    chk("arst_err", 128'(err_underflow), 128'(0));
    chk("arst_req_ready", 128'(req_ready), 128'(0));
    modelReset();
    @(posedge pClk);
    #1;
    SoftReset_n = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    req_valid = '0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
